// File: rtl/grapheme_lb_ctrl_if.sv
// Local-bus port bundle for the grapheme node register decoder.
// Master issues one-cycle read/write strobes. The slave always accepts and answers exactly one cycle later.
interface grapheme_lb_ctrl_if #(
  parameter int LB_DATA_W = 32,
  parameter int LB_ADDR_W = 6
);
  // Handshake: lb_wr_en / lb_rd_en are single-cycle strobes with no ready/backpressure.
  // lb_wr_valid / lb_rd_valid pulse for one cycle, exactly one cycle after the strobe.
  // lb_rd_data is qualified by lb_rd_valid and holds its value between reads.
  logic                 lb_wr_en;
  logic                 lb_rd_en;
  logic [LB_ADDR_W-1:0] lb_addr;
  logic [LB_DATA_W-1:0] lb_wr_data;
  logic                 lb_wr_valid;
  logic                 lb_rd_valid;
  logic [LB_DATA_W-1:0] lb_rd_data;

  modport master (
    output lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
    input  lb_wr_valid, lb_rd_valid, lb_rd_data
  );

  modport slave (
    input  lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
    output lb_wr_valid, lb_rd_valid, lb_rd_data
  );
endinterface

// File: rtl/grapheme_lb_ctrl.sv
// LB register decoder for NUM_NODES grapheme nodes: enable/clear control, status readback, sticky IRQs.
// Define GRAPHEME_LB_IRQ_EN to build the IRQ_STAT/IRQ_MASK registers and the irq output.
module grapheme_lb_ctrl #(
  parameter string                MODULE_NAME     = "GRAPHEME_LB_CTRL",
  parameter int                   NUM_NODES       = 4,
  parameter int                   LB_DATA_W       = 32,
  parameter int                   LB_ADDR_W       = 6,
  parameter int                   CLR_PULSE_W     = 4,
  parameter logic [LB_DATA_W-1:0] DEFAULT_REG_VAL = 'hdeadbabe
) (
  input  logic                 clk,
  input  logic                 rst_n,
  grapheme_lb_ctrl_if.slave    lb,
  output logic [NUM_NODES-1:0] gnode_en,
  output logic [NUM_NODES-1:0] gnode_clear_flags,
  input  logic [LB_DATA_W-1:0] gnode_status [NUM_NODES],
  input  logic [NUM_NODES-1:0] gnode_event,
  output logic                 irq
);
  localparam int               NODE_W   = LB_ADDR_W - 2;
  localparam int               CNT_W    = $clog2(CLR_PULSE_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLR_PULSE_W);

  logic [NODE_W-1:0]    node_idx;
  logic [1:0]           reg_idx;
  logic                 mapped;
  logic [NUM_NODES-1:0] node_sel;
  logic [NUM_NODES-1:0] ctrl_wr;
  logic [CNT_W-1:0]     clr_cnt [NUM_NODES];
  logic [LB_DATA_W-1:0] rd_word;
  logic                 wr_valid_q;
  logic                 rd_valid_q;
  logic [LB_DATA_W-1:0] rd_data_q;
  logic                 unused_wr_bits;

  assign node_idx       = lb.lb_addr[LB_ADDR_W-1:2];
  assign reg_idx        = lb.lb_addr[1:0];
  // Extra bit so NUM_NODES == 2**NODE_W does not wrap to zero in the compare.
  assign mapped         = {1'b0, node_idx} < (NODE_W + 1)'(NUM_NODES);
  assign unused_wr_bits = ^lb.lb_wr_data[LB_DATA_W-1:2];

  assign lb.lb_wr_valid = wr_valid_q;
  assign lb.lb_rd_valid = rd_valid_q;
  assign lb.lb_rd_data  = rd_data_q;

  always_comb begin
    node_sel          = '0;
    ctrl_wr           = '0;
    gnode_clear_flags = '0;
    for (int n = 0; n < NUM_NODES; n++) begin
      node_sel[n]          = mapped && (node_idx == NODE_W'(n));
      ctrl_wr[n]           = lb.lb_wr_en && node_sel[n] && (reg_idx == 2'd0);
      gnode_clear_flags[n] = (clr_cnt[n] != '0);
    end
  end

`ifdef GRAPHEME_LB_IRQ_EN
  logic [NUM_NODES-1:0] irq_stat;
  logic [NUM_NODES-1:0] irq_mask;
  logic [NUM_NODES-1:0] stat_w1c;
  logic [NUM_NODES-1:0] mask_wr;

  always_comb begin
    stat_w1c = '0;
    mask_wr  = '0;
    for (int n = 0; n < NUM_NODES; n++) begin
      stat_w1c[n] = lb.lb_wr_en && node_sel[n] && (reg_idx == 2'd2) && lb.lb_wr_data[0];
      mask_wr[n]  = lb.lb_wr_en && node_sel[n] && (reg_idx == 2'd3);
    end
  end

  // A new event outranks a same-cycle W1C so no event is ever lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_stat <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      irq_stat <= gnode_event | (irq_stat & ~stat_w1c);
      for (int n = 0; n < NUM_NODES; n++) begin
        if (mask_wr[n]) irq_mask[n] <= lb.lb_wr_data[0];
      end
      irq <= |(irq_stat & irq_mask);
    end
  end
`else
  logic unused_event;
  assign unused_event = ^gnode_event;
  assign irq          = 1'b0;
`endif

  // Read mux sees pre-write register values, so a same-cycle read returns old data.
  always_comb begin
    rd_word = DEFAULT_REG_VAL;
    for (int n = 0; n < NUM_NODES; n++) begin
      if (node_sel[n]) begin
        case (reg_idx)
          2'd0: begin
            rd_word      = '0;
            rd_word[1:0] = {gnode_clear_flags[n], gnode_en[n]};
          end
          2'd1: rd_word = gnode_status[n];
`ifdef GRAPHEME_LB_IRQ_EN
          2'd2: begin
            rd_word    = '0;
            rd_word[0] = irq_stat[n];
          end
          2'd3: begin
            rd_word    = '0;
            rd_word[0] = irq_mask[n];
          end
`endif
          default: rd_word = DEFAULT_REG_VAL;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      gnode_en   <= '0;
      for (int n = 0; n < NUM_NODES; n++) clr_cnt[n] <= '0;
    end else begin
      wr_valid_q <= lb.lb_wr_en;
      rd_valid_q <= lb.lb_rd_en;
      if (lb.lb_rd_en) rd_data_q <= rd_word;
      for (int n = 0; n < NUM_NODES; n++) begin
        if (ctrl_wr[n]) gnode_en[n] <= lb.lb_wr_data[0];
        // Reload on every clr write, which stretches a pulse already in flight.
        if (ctrl_wr[n] && lb.lb_wr_data[1]) clr_cnt[n] <= CNT_LOAD;
        else if (clr_cnt[n] != '0)          clr_cnt[n] <= clr_cnt[n] - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_grapheme_lb_ctrl.sv
// Directed self-checking bench for grapheme_lb_ctrl; read data is scoreboarded through exp_q.
// Expectations for the IRQ registers follow whether GRAPHEME_LB_IRQ_EN is defined.
module tb_grapheme_lb_ctrl;
  localparam int          NUM_NODES   = 4;
  localparam int          LB_DATA_W   = 32;
  localparam int          LB_ADDR_W   = 6;
  localparam int          CLR_PULSE_W = 4;
  localparam logic [31:0] DEF_VAL     = 32'hdeadbabe;

  logic                 clk;
  logic                 rst_n;
  logic [LB_DATA_W-1:0] gnode_status [NUM_NODES];
  logic [NUM_NODES-1:0] gnode_event;
  logic [NUM_NODES-1:0] gnode_en;
  logic [NUM_NODES-1:0] gnode_clear_flags;
  logic                 irq;

  logic [LB_DATA_W-1:0] exp_q[$];
  logic                 exp_wr_v;
  logic                 exp_rd_v;
  int                   checks;
  int                   errors;
  int                   pulse_len;

  grapheme_lb_ctrl_if #(.LB_DATA_W(LB_DATA_W), .LB_ADDR_W(LB_ADDR_W)) lb ();

  grapheme_lb_ctrl #(
    .NUM_NODES      (NUM_NODES),
    .LB_DATA_W      (LB_DATA_W),
    .LB_ADDR_W      (LB_ADDR_W),
    .CLR_PULSE_W    (CLR_PULSE_W),
    .DEFAULT_REG_VAL(DEF_VAL)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lb               (lb),
    .gnode_en         (gnode_en),
    .gnode_clear_flags(gnode_clear_flags),
    .gnode_status     (gnode_status),
    .gnode_event      (gnode_event),
    .irq              (irq)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Driver tasks: strobes asserted on the falling edge, sampled by the next rising edge.
  task automatic write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    lb.lb_wr_en = 1'b1; lb.lb_addr = a; lb.lb_wr_data = d;
    @(negedge clk);
    lb.lb_wr_en = 1'b0;
  endtask

  task automatic read(input logic [5:0] a, input logic [31:0] e);
    @(negedge clk);
    lb.lb_rd_en = 1'b1; lb.lb_addr = a; exp_q.push_back(e);
    @(negedge clk);
    lb.lb_rd_en = 1'b0;
  endtask

  task automatic write_read(input logic [5:0] a, input logic [31:0] d, input logic [31:0] e);
    @(negedge clk);
    lb.lb_wr_en = 1'b1; lb.lb_rd_en = 1'b1; lb.lb_addr = a; lb.lb_wr_data = d;
    exp_q.push_back(e);
    @(negedge clk);
    lb.lb_wr_en = 1'b0; lb.lb_rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_event(input logic [NUM_NODES-1:0] ev);
    @(negedge clk);
    gnode_event = ev;
    @(negedge clk);
    gnode_event = '0;
  endtask

  // Scoreboard / monitor: acknowledges are due one cycle after each strobe.
  always @(posedge clk) begin
    exp_wr_v <= rst_n & lb.lb_wr_en;
    exp_rd_v <= rst_n & lb.lb_rd_en;
  end

  always @(negedge clk) begin
    if (lb.lb_wr_valid || exp_wr_v) check("wr_valid", 32'(lb.lb_wr_valid), 32'(exp_wr_v));
    if (lb.lb_rd_valid || exp_rd_v) check("rd_valid", 32'(lb.lb_rd_valid), 32'(exp_rd_v));
    if (lb.lb_rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got data 0x%08h required no read response", lb.lb_rd_data);
      end else begin
        check("rd_data", lb.lb_rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    exp_wr_v = 1'b0; exp_rd_v = 1'b0;
    lb.lb_wr_en = 1'b0; lb.lb_rd_en = 1'b0; lb.lb_addr = '0; lb.lb_wr_data = '0;
    gnode_event = '0;
    gnode_status[0] = 32'h0000_00a0;
    gnode_status[1] = 32'h0000_00b1;
    gnode_status[2] = 32'h0000_00c2;
    gnode_status[3] = 32'h1234_5678;

    idle(3);
    check("reset_gnode_en", 32'(gnode_en), 32'h0);
    check("reset_clear_flags", 32'(gnode_clear_flags), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_rd_data", lb.lb_rd_data, 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Enable write to node 2
    write(6'h08, 32'h1);
    check("gnode_en_node2", 32'(gnode_en), 32'h4);
    read(6'h08, 32'h1);

    // Same-cycle write and read returns the pre-write value
    write_read(6'h04, 32'h1, 32'h0);
    read(6'h04, 32'h1);
    check("gnode_en_node1_2", 32'(gnode_en), 32'h6);

    // Clear pulse length
    write(6'h00, 32'h2);
    pulse_len = 0;
    while (gnode_clear_flags[0] && pulse_len < 20) begin
      pulse_len++;
      @(negedge clk);
    end
    check("clr_pulse_len", 32'(pulse_len), 32'(CLR_PULSE_W));
    check("clr_no_other_nodes", 32'(gnode_clear_flags), 32'h0);

    // Re-write during the second pulse cycle stretches the pulse to 6 cycles
    write(6'h00, 32'h2);
    pulse_len = 0;
    while (gnode_clear_flags[0] && pulse_len < 20) begin
      pulse_len++;
      if (pulse_len == 2) begin
        lb.lb_wr_en = 1'b1; lb.lb_addr = 6'h00; lb.lb_wr_data = 32'h2;
      end else begin
        lb.lb_wr_en = 1'b0;
      end
      @(negedge clk);
    end
    lb.lb_wr_en = 1'b0;
    check("clr_pulse_extended", 32'(pulse_len), 32'h6);

    // CTRL bit1 reads 1 while the pulse runs, 0 afterwards
    write(6'h0c, 32'h2);
    read(6'h0c, 32'h2);
    idle(5);
    read(6'h0c, 32'h0);

    // Status and unmapped addresses
    read(6'h0d, 32'h1234_5678);
    read(6'h05, 32'h0000_00b1);
    write(6'h05, 32'hffff_ffff);
    read(6'h05, 32'h0000_00b1);
    read(6'h14, DEF_VAL);
    write(6'h14, 32'h3);
    check("unmapped_write_dropped", 32'(gnode_en), 32'h6);
    check("unmapped_write_no_clr", 32'(gnode_clear_flags), 32'h0);
    read(6'h3f, DEF_VAL);

`ifdef GRAPHEME_LB_IRQ_EN
    // Unmasked event sets the sticky bit but leaves irq low
    read(6'h02, 32'h0);
    pulse_event(4'b0100);
    idle(2);
    check("irq_unmasked_low", 32'(irq), 32'h0);
    read(6'h0a, 32'h1);
    write(6'h0a, 32'h1);
    read(6'h0a, 32'h0);

    // Masked event: irq rises two cycles after the event
    write(6'h07, 32'h1);
    read(6'h07, 32'h1);
    @(negedge clk);
    gnode_event = 4'b0010;
    @(negedge clk);
    gnode_event = '0;
    check("irq_event_plus1", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_event_plus2", 32'(irq), 32'h1);
    read(6'h06, 32'h1);

    // W1C drops irq two cycles after the write
    write(6'h06, 32'h1);
    check("irq_w1c_plus1", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_w1c_plus2", 32'(irq), 32'h0);
    read(6'h06, 32'h0);

    // Event and W1C on the same node in the same cycle: set wins
    @(negedge clk);
    lb.lb_wr_en = 1'b1; lb.lb_addr = 6'h06; lb.lb_wr_data = 32'h1;
    gnode_event = 4'b0010;
    @(negedge clk);
    lb.lb_wr_en = 1'b0;
    gnode_event = '0;
    read(6'h06, 32'h1);
    check("irq_set_wins", 32'(irq), 32'h1);
    write(6'h06, 32'h1);
    idle(2);
    check("irq_cleared_again", 32'(irq), 32'h0);
`else
    // IRQ registers absent: default read data, writes ignored, irq held low
    read(6'h02, DEF_VAL);
    write(6'h07, 32'h1);
    read(6'h07, DEF_VAL);
    pulse_event(4'b1111);
    check("irq_off_plus1", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_off_plus2", 32'(irq), 32'h0);
    idle(2);
    check("irq_off_later", 32'(irq), 32'h0);
    read(6'h06, DEF_VAL);
`endif

    // Reset in the middle of a clear pulse with enables set
`ifdef GRAPHEME_LB_IRQ_EN
    pulse_event(4'b0010);
    idle(1);
    check("irq_before_reset", 32'(irq), 32'h1);
`endif
    write(6'h00, 32'h3);
    read(6'h00, 32'h3);
    check("pulse_before_reset", 32'(gnode_clear_flags), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_gnode_en", 32'(gnode_en), 32'h0);
    check("rst_clear_flags", 32'(gnode_clear_flags), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rd_data", lb.lb_rd_data, 32'h0);
    check("rst_rd_valid", 32'(lb.lb_rd_valid), 32'h0);
    check("rst_wr_valid", 32'(lb.lb_wr_valid), 32'h0);
    idle(1);
    rst_n = 1'b1;
    read(6'h00, 32'h0);
    read(6'h04, 32'h0);
`ifdef GRAPHEME_LB_IRQ_EN
    read(6'h06, 32'h0);
    read(6'h07, 32'h0);
`else
    read(6'h07, DEF_VAL);
`endif
    check("post_reset_clear_flags", 32'(gnode_clear_flags), 32'h0);

    idle(3);
    check("rd_queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
